// File: rtl/vector_writeback_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_writeback_sequencer_if
// Desc     : ALU result stream and result-memory write bus of the writeback
//            sequencer; master is the sequencer, slave the surrounding logic.
// Revision : 1.0
// ============================================================================
interface vector_writeback_sequencer_if #(
  parameter int W          = 512,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic                  read_again;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [W-1:0]          mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, read_again, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, read_again, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vector_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_writeback_sequencer
// Desc     : Buffers ALU result words and writes them to sequential memory
//            addresses, pacing operand fetch with read_again credits.
//            Define WB_CYCLE_COUNT_EN to add the cycle_count port.
// Revision : 1.0
// ============================================================================
module vector_writeback_sequencer #(
  parameter int NO_OF_UNITS   = 8,
  parameter int ELEMENT_WIDTH = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  total,
  vector_writeback_sequencer_if.master bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef WB_CYCLE_COUNT_EN
  ,
  output logic [31:0]                  cycle_count
`endif
);

  localparam int c_WORD_W = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W  = c_PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [31:0]         r_words;
  logic [31:0]         r_req_cnt;
  logic [31:0]         r_rcv_cnt;
  logic [31:0]         r_wr_cnt;
  logic [c_WORD_W-1:0] r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [c_WORD_W-1:0] r_mem_wdata;
  logic                r_err;

  logic        w_busy;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_start_ok;
  logic        w_credit;
  logic [31:0] w_start_words;
  logic [31:0] w_outstanding;

  assign w_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_full        = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_push        = bus.in_valid && !w_full && w_busy;
  assign w_pop         = !w_empty && w_busy;
  assign w_start_ok    = start && (r_state == S_IDLE);
  assign w_start_words = total / 32'(NO_OF_UNITS);
  assign w_outstanding = r_req_cnt - r_rcv_cnt;

  // Requested-but-unreturned words plus buffered words never exceed the FIFO,
  // so a credited source can never find the buffer full.
  assign w_credit = (r_state == S_RUN) && (r_req_cnt < r_words) &&
                    ((w_outstanding + 32'(r_count)) < 32'(FIFO_DEPTH));

  assign bus.in_ready   = !w_full;
  assign bus.read_again = w_credit;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign busy           = w_busy;
  assign done           = (r_state == S_DONE);
  assign err            = r_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_words     <= '0;
      r_req_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_words   <= w_start_words;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
            r_wr_cnt  <= '0;
            r_state   <= (w_start_words == 32'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (r_req_cnt == r_words) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_wr_cnt == r_words) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_credit) r_req_cnt <= r_req_cnt + 32'd1;

      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
        r_rcv_cnt <= r_rcv_cnt + 32'd1;
      end

      r_mem_we <= w_pop;
      if (w_pop) begin
        r_mem_addr  <= r_wr_cnt[ADDR_WIDTH-1:0];
        r_mem_wdata <= r_fifo[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + c_PTR_W'(1);
        r_wr_cnt    <= r_wr_cnt + 32'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (bus.in_valid && (r_state == S_IDLE)) r_err <= 1'b1;
    end
  end

`ifdef WB_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_start_ok) begin
      r_cycle_count <= '0;
    end else if (w_busy) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_writeback_sequencer
// Desc     : Scoreboard bench for vector_writeback_sequencer with a credited
//            source model of configurable latency and stall.
// Revision : 1.0
// ============================================================================
module tb_vector_writeback_sequencer;

  localparam int c_W = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] total;
  logic        busy;
  logic        done;
  logic        err;
`ifdef WB_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  vector_writeback_sequencer_if #(.W(c_W), .ADDR_WIDTH(32)) bus ();

  vector_writeback_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .total (total),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef WB_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [c_W-1:0] got, input logic [c_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [c_W-1:0] word_val(input int s);
    logic [c_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*64 +: 64] = {32'(s), 32'hC0DE_0000 ^ 32'(i)};
    return v;
  endfunction

  // Source model and monitor state
  bit             src_on = 1'b0;
  int             lat = 2, stall_after = 0, stall_len = 0, stall_until = 0;
  int             cyc = 0, req_seen = 0, word_seq = 0, next_addr = 0;
  int             due_q[$];
  int             exp_addr_q[$];
  logic [c_W-1:0] exp_data_q[$];
  int             we_count = 0, ra_count = 0, done_count = 0, busy_cycles = 0;
  int             max_inflight = 0, last_we_cyc = 0, done_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we === 1'b1) begin
        we_count++;
        last_we_cyc = cyc;
        chk("sb_has_entry", c_W'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) begin
          chk("wr_addr", c_W'(bus.mem_addr), c_W'(exp_addr_q.pop_front()));
          chk("wr_data", bus.mem_wdata, exp_data_q.pop_front());
        end
      end
      if (bus.read_again === 1'b1) ra_count++;
      if (done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (busy === 1'b1) busy_cycles++;
      if (ra_count - we_count > max_inflight) max_inflight = ra_count - we_count;

      if (src_on) begin
        if (bus.read_again === 1'b1) begin
          req_seen++;
          due_q.push_back(cyc + lat);
          if (req_seen == stall_after) stall_until = cyc + stall_len;
        end
        if (due_q.size() != 0 && due_q[0] <= cyc && cyc >= stall_until) begin
          bus.in_valid = 1'b1;
          bus.in_data  = word_val(word_seq);
          if (bus.in_ready === 1'b1 && busy === 1'b1) begin
            exp_addr_q.push_back(next_addr);
            exp_data_q.push_back(word_val(word_seq));
            next_addr++;
            word_seq++;
            void'(due_q.pop_front());
          end
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
  end

  task automatic begin_pass(input int tot, input int latency, input int st_after,
                            input int st_len, input bit restart);
    we_count = 0; ra_count = 0; done_count = 0; busy_cycles = 0; max_inflight = 0;
    req_seen = 0; next_addr = 0; stall_until = 0;
    due_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    lat = latency; stall_after = st_after; stall_len = st_len;
    src_on = 1'b1;
    @(negedge clk);
    total = 32'(tot);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (restart) begin
      repeat (3) @(negedge clk);
      total = 32'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_pass(input int tot, input int latency, input int st_after,
                          input int st_len, input bit restart);
    int words;
    int budget;
    words = tot / 8;
    begin_pass(tot, latency, st_after, st_len, restart);
    budget = 0;
    while (done_count == 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("pass_in_time", c_W'(budget < 300), 1);
    repeat (3) @(negedge clk);
    src_on = 1'b0;
    chk("n_writes", c_W'(we_count), c_W'(words));
    chk("n_read_again", c_W'(ra_count), c_W'(words));
    chk("n_done", c_W'(done_count), 1);
    chk("sb_drained", c_W'(exp_addr_q.size()), 0);
    chk("inflight_le_depth", c_W'(max_inflight <= 4), 1);
    if (words > 0) chk("done_after_last_wr", c_W'(done_cyc - last_we_cyc), 1);
    else chk("busy_never", c_W'(busy_cycles), 0);
  endtask

  initial begin
    int budget;
    int we_before;
    reset = 1'b1; start = 1'b0; total = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", c_W'(bus.in_ready), 1);
    chk("rst_mem_we", c_W'(bus.mem_we), 0);
    chk("rst_mem_addr", c_W'(bus.mem_addr), 0);
    chk("rst_read_again", c_W'(bus.read_again), 0);
    chk("rst_busy", c_W'(busy), 0);
    chk("rst_done", c_W'(done), 0);
    chk("rst_err", c_W'(err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Latency-2 source, then a source stalled after the 4th request
    run_pass(64, 2, 0, 0, 1'b0);
    run_pass(64, 2, 4, 10, 1'b0);
    chk("stall_hits_depth", c_W'(max_inflight), 4);

    // Zero-word passes
    run_pass(5, 2, 0, 0, 1'b0);
    run_pass(0, 2, 0, 0, 1'b0);

    // Reset after the 3rd write aborts the pass
    begin_pass(64, 2, 0, 0, 1'b0);
    budget = 0;
    while (we_count < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("t4_third_write", c_W'(budget < 100), 1);
    src_on = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", c_W'(bus.mem_we), 0);
    chk("abort_busy", c_W'(busy), 0);
    chk("abort_read_again", c_W'(bus.read_again), 0);
    chk("abort_in_ready", c_W'(bus.in_ready), 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", c_W'(done_count), 0);
    run_pass(64, 2, 0, 0, 1'b0);

    // in_valid while idle, then start while running
    we_before = we_count;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = word_val(99);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_write", c_W'(we_count), c_W'(we_before));
    chk("idle_err", c_W'(err), 1);
    run_pass(64, 2, 0, 0, 1'b1);
    chk("err_sticky", c_W'(err), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", c_W'(err), 0);

`ifdef WB_CYCLE_COUNT_EN
    run_pass(32, 0, 0, 0, 1'b0);
    chk("cycle_count", c_W'(cycle_count), 6);
    chk("busy_cycles", c_W'(busy_cycles), 6);
    repeat (3) @(negedge clk);
    chk("cycle_count_hold", c_W'(cycle_count), 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
